// File: rtl/snake_pkg.sv
`default_nettype none
// ============================================================================
// Package  : snake_pkg
// Purpose  : Shared codes, FSM encodings and grid constants for the snake core.
// Revision : 1.0
// ============================================================================
package snake_pkg;

  localparam int c_cell_log2 = 3;
  localparam int c_grid_w    = 80;
  localparam int c_grid_h    = 60;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_OVER = 2'b10
  } state_t;

  localparam logic [1:0] c_scr_title = 2'b00;
  localparam logic [1:0] c_scr_play  = 2'b01;

  typedef struct packed {
    logic [6:0] x;
    logic [5:0] y;
  } cell_t;

  localparam cell_t c_start_cell = {7'd40, 6'd30};
  localparam cell_t c_food_cell  = {7'd20, 6'd15};

  // Opposite directions share the axis bit and differ in the sign bit.
  function automatic logic is_reverse(input dir_t a, input dir_t b);
    return (a[1] == b[1]) && (a[0] != b[0]);
  endfunction

endpackage : snake_pkg
`default_nettype wire

// File: rtl/snake_game_core_bcd.sv
`default_nettype none
// ============================================================================
// Module   : bcd_counter4
// Purpose  : Four-digit BCD up-counter with clear and wrap from 9999 to 0000.
// Revision : 1.0
// ============================================================================
module bcd_counter4 (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_clear,
  input  logic        i_inc,
  output logic [15:0] o_digits
);

  logic [15:0] r_digits;
  logic [15:0] w_next;
  logic        w_carry;

  always_comb begin
    w_next  = r_digits;
    w_carry = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (w_carry) begin
        if (r_digits[4*k +: 4] == 4'd9) begin
          w_next[4*k +: 4] = 4'd0;
        end else begin
          w_next[4*k +: 4] = r_digits[4*k +: 4] + 4'd1;
          w_carry          = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_digits <= 16'h0000;
    end else if (i_clear) begin
      r_digits <= 16'h0000;
    end else if (i_inc) begin
      r_digits <= w_next;
    end
  end

  assign o_digits = r_digits;

endmodule : bcd_counter4
`default_nettype wire

// File: rtl/snake_game_core.sv
`default_nettype none
// ============================================================================
// Module   : snake_game_core
// Purpose  : Snake game-state engine: movement, wall/self/food hits, score.
// Revision : 1.0
// ============================================================================
module snake_game_core
  import snake_pkg::*;
#(
  parameter int CELL_LOG2 = c_cell_log2,
  parameter int GRID_W    = c_grid_w,
  parameter int GRID_H    = c_grid_h,
  parameter int MAX_LEN   = 8,
  parameter int TICK_DIV  = 2500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] moveState,
  input  logic       isPaused,
  input  logic [1:0] currentScreen,
  input  logic [9:0] rand_x,
  input  logic [9:0] rand_y,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  output logic [9:0] headX,
  output logic [9:0] headY,
  output logic [9:0] foodX,
  output logic [9:0] foodY,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic [3:0] score3,
  output logic [3:0] score4,
  output logic       body_on,
  output logic       game_over
);

  localparam int c_cnt_w = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int c_len_w = $clog2(MAX_LEN + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(TICK_DIV - 1);
  localparam logic [c_len_w-1:0] c_len_max = c_len_w'(MAX_LEN);

  state_t              r_state, w_state_nxt;
  logic [c_cnt_w-1:0]  r_cnt;
  dir_t                r_dir, r_dir_req, w_dir_eff;
  cell_t               r_body [MAX_LEN];
  logic [c_len_w-1:0]  r_len;
  cell_t               r_food;
  logic                r_food_pending;
  logic                r_body_on;
  logic                r_game_over;

  cell_t               w_next, w_new_head, w_rand_cell;
  logic                w_tick, w_wall, w_hit, w_step, w_eat, w_reinit;
  logic                w_rand_ok, w_food_try;
  logic [9:0]          w_rand_xc, w_rand_yc, w_pix_xc, w_pix_yc;
  logic [MAX_LEN-1:0]  w_self_hit, w_pix_hit;
  logic [15:0]         w_score;

  assign w_reinit  = (r_state == ST_IDLE) && (currentScreen == c_scr_play);
  assign w_tick    = (r_state == ST_RUN) && !isPaused && (r_cnt == c_cnt_max);
  assign w_dir_eff = ((r_len > c_len_w'(1)) && is_reverse(r_dir_req, r_dir)) ? r_dir : r_dir_req;

  always_comb begin
    w_next = r_body[0];
    w_wall = 1'b0;
    case (w_dir_eff)
      DIR_UP:    if (r_body[0].y == 6'd0) w_wall = 1'b1;
                 else w_next.y = r_body[0].y - 6'd1;
      DIR_DOWN:  if (r_body[0].y == 6'(GRID_H - 1)) w_wall = 1'b1;
                 else w_next.y = r_body[0].y + 6'd1;
      DIR_LEFT:  if (r_body[0].x == 7'd0) w_wall = 1'b1;
                 else w_next.x = r_body[0].x - 7'd1;
      default:   if (r_body[0].x == 7'(GRID_W - 1)) w_wall = 1'b1;
                 else w_next.x = r_body[0].x + 7'd1;
    endcase
  end

  assign w_pix_xc      = pix_x >> CELL_LOG2;
  assign w_pix_yc      = pix_y >> CELL_LOG2;
  assign w_self_hit[0] = 1'b0;
  assign w_pix_hit[0]  = 1'b0;

  // Slots at or beyond len hold stale history and must never match.
  for (genvar k = 1; k < MAX_LEN; k++) begin : g_cmp
    logic w_active;
    assign w_active      = c_len_w'(k) < r_len;
    assign w_self_hit[k] = w_active && (r_body[k] == w_next);
    assign w_pix_hit[k]  = w_active && ({3'b000, r_body[k].x} == w_pix_xc) &&
                           ({4'b0000, r_body[k].y} == w_pix_yc);
  end

  assign w_hit      = w_wall || (|w_self_hit);
  assign w_step     = w_tick && !w_hit;
  assign w_eat      = (w_next == r_food);
  assign w_new_head = w_step ? w_next : r_body[0];

  assign w_rand_xc   = rand_x >> CELL_LOG2;
  assign w_rand_yc   = rand_y >> CELL_LOG2;
  assign w_rand_cell = {w_rand_xc[6:0], w_rand_yc[5:0]};
  assign w_rand_ok   = (w_rand_xc < 10'(GRID_W)) && (w_rand_yc < 10'(GRID_H)) &&
                       (w_rand_cell != w_new_head);
  assign w_food_try  = (w_step && w_eat) || r_food_pending;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (currentScreen == c_scr_play) w_state_nxt = ST_RUN;
      ST_RUN:  if (currentScreen == c_scr_title) w_state_nxt = ST_IDLE;
               else if (w_tick && w_hit) w_state_nxt = ST_OVER;
      ST_OVER: if (currentScreen == c_scr_title) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_game_over <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_game_over <= (w_state_nxt == ST_OVER);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt     <= '0;
      r_dir     <= DIR_RIGHT;
      r_dir_req <= DIR_RIGHT;
    end else begin
      r_dir_req <= dir_t'(moveState);
      if (w_reinit) begin
        r_cnt <= '0;
        r_dir <= DIR_RIGHT;
      end else begin
        if ((r_state == ST_RUN) && !isPaused) begin
          r_cnt <= (r_cnt == c_cnt_max) ? '0 : r_cnt + 1'b1;
        end
        if (w_tick) begin
          r_dir <= w_dir_eff;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < MAX_LEN; k++) r_body[k] <= c_start_cell;
      r_len <= c_len_w'(1);
    end else if (w_reinit) begin
      for (int k = 0; k < MAX_LEN; k++) r_body[k] <= c_start_cell;
      r_len <= c_len_w'(1);
    end else if (w_step) begin
      for (int k = MAX_LEN - 1; k > 0; k--) r_body[k] <= r_body[k-1];
      r_body[0] <= w_next;
      if (w_eat && (r_len < c_len_max)) begin
        r_len <= r_len + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_food         <= c_food_cell;
      r_food_pending <= 1'b0;
      r_body_on      <= 1'b0;
    end else begin
      r_body_on <= |w_pix_hit;
      if (w_reinit) begin
        r_food         <= c_food_cell;
        r_food_pending <= 1'b0;
      end else if (w_food_try) begin
        if (w_rand_ok) begin
          r_food         <= w_rand_cell;
          r_food_pending <= 1'b0;
        end else begin
          r_food_pending <= 1'b1;
        end
      end
    end
  end

  bcd_counter4 u_score (
    .clk      (clk),
    .reset    (reset),
    .i_clear  (w_reinit),
    .i_inc    (w_step && w_eat),
    .o_digits (w_score)
  );

  assign headX     = {3'b000, r_body[0].x} << CELL_LOG2;
  assign headY     = {4'b0000, r_body[0].y} << CELL_LOG2;
  assign foodX     = {3'b000, r_food.x} << CELL_LOG2;
  assign foodY     = {4'b0000, r_food.y} << CELL_LOG2;
  assign score1    = w_score[3:0];
  assign score2    = w_score[7:4];
  assign score3    = w_score[11:8];
  assign score4    = w_score[15:12];
  assign body_on   = r_body_on;
  assign game_over = r_game_over;

endmodule : snake_game_core
`default_nettype wire

// File: tb/tb_snake_game_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_snake_game_core
// Purpose  : Directed self-checking bench for snake_game_core and bcd_counter4.
// Revision : 1.0
// ============================================================================
module tb_snake_game_core;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] moveState;
  logic       isPaused;
  logic [1:0] currentScreen;
  logic [9:0] rand_x, rand_y, pix_x, pix_y;
  logic [9:0] headX, headY, foodX, foodY;
  logic [3:0] score1, score2, score3, score4;
  logic       body_on, game_over;
  logic       bcd_clear, bcd_inc;
  logic [15:0] bcd_digits;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  snake_game_core #(
    .CELL_LOG2 (3),
    .GRID_W    (80),
    .GRID_H    (60),
    .MAX_LEN   (8),
    .TICK_DIV  (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .moveState     (moveState),
    .isPaused      (isPaused),
    .currentScreen (currentScreen),
    .rand_x        (rand_x),
    .rand_y        (rand_y),
    .pix_x         (pix_x),
    .pix_y         (pix_y),
    .headX         (headX),
    .headY         (headY),
    .foodX         (foodX),
    .foodY         (foodY),
    .score1        (score1),
    .score2        (score2),
    .score3        (score3),
    .score4        (score4),
    .body_on       (body_on),
    .game_over     (game_over)
  );

  bcd_counter4 u_bcd (
    .clk      (clk),
    .reset    (reset),
    .i_clear  (bcd_clear),
    .i_inc    (bcd_inc),
    .o_digits (bcd_digits)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic run_ticks(input int n);
    step(4 * n);
  endtask

  task automatic test_reset;
    reset = 1'b1; moveState = 2'b11; isPaused = 1'b0; currentScreen = 2'b00;
    rand_x = 10'd80; rand_y = 10'd80; pix_x = 10'd0; pix_y = 10'd0;
    bcd_clear = 1'b0; bcd_inc = 1'b0;
    step(2);
    checks++; if (headX !== 10'd320) begin errors++; $display("FAIL reset_headX got %0d exp 320", headX); end
    checks++; if (headY !== 10'd240) begin errors++; $display("FAIL reset_headY got %0d exp 240", headY); end
    checks++; if (foodX !== 10'd160) begin errors++; $display("FAIL reset_foodX got %0d exp 160", foodX); end
    checks++; if (foodY !== 10'd120) begin errors++; $display("FAIL reset_foodY got %0d exp 120", foodY); end
    checks++; if ({score4, score3, score2, score1} !== 16'h0000) begin errors++; $display("FAIL reset_score got %h exp 0000", {score4, score3, score2, score1}); end
    checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL reset_game_over got %b exp 0", game_over); end
    checks++; if (body_on !== 1'b0) begin errors++; $display("FAIL reset_body_on got %b exp 0", body_on); end
    reset = 1'b0;
    step(5);
    checks++; if (headX !== 10'd320) begin errors++; $display("FAIL idle_hold_headX got %0d exp 320", headX); end
  endtask

  task automatic test_move;
    currentScreen = 2'b01;
    step(1);
    step(11);
    checks++; if (headX !== 10'd336) begin errors++; $display("FAIL move_two_ticks got %0d exp 336", headX); end
    step(1);
    checks++; if (headX !== 10'd344) begin errors++; $display("FAIL move_three_ticks got %0d exp 344", headX); end
    checks++; if (headY !== 10'd240) begin errors++; $display("FAIL move_headY got %0d exp 240", headY); end
    checks++; if ({score4, score3, score2, score1} !== 16'h0000) begin errors++; $display("FAIL move_score got %h exp 0000", {score4, score3, score2, score1}); end
  endtask

  task automatic test_food;
    moveState = 2'b00;
    run_ticks(15);
    checks++; if (headY !== 10'd120) begin errors++; $display("FAIL food_up_headY got %0d exp 120", headY); end
    moveState = 2'b10;
    run_ticks(22);
    checks++; if (headX !== 10'd168) begin errors++; $display("FAIL food_left_headX got %0d exp 168", headX); end
    run_ticks(1);
    checks++; if (headX !== 10'd160) begin errors++; $display("FAIL food_eat_headX got %0d exp 160", headX); end
    checks++; if ({score4, score3, score2, score1} !== 16'h0001) begin errors++; $display("FAIL food_score got %h exp 0001", {score4, score3, score2, score1}); end
    checks++; if (foodX !== 10'd80) begin errors++; $display("FAIL food_reload_x got %0d exp 80", foodX); end
    checks++; if (foodY !== 10'd80) begin errors++; $display("FAIL food_reload_y got %0d exp 80", foodY); end
  endtask

  task automatic test_reverse;
    moveState = 2'b11;
    run_ticks(1);
    checks++; if (headX !== 10'd152) begin errors++; $display("FAIL reverse_ignored_headX got %0d exp 152", headX); end
    moveState = 2'b00;
    run_ticks(1);
    checks++; if (headY !== 10'd112) begin errors++; $display("FAIL turn_up_headY got %0d exp 112", headY); end
    checks++; if (headX !== 10'd152) begin errors++; $display("FAIL turn_up_headX got %0d exp 152", headX); end
    pix_x = 10'd152; pix_y = 10'd120;
    step(1);
    checks++; if (body_on !== 1'b1) begin errors++; $display("FAIL body_on_segment got %b exp 1", body_on); end
    pix_x = 10'd155; pix_y = 10'd113;
    step(1);
    checks++; if (body_on !== 1'b0) begin errors++; $display("FAIL body_on_head_excluded got %b exp 0", body_on); end
    step(2);
  endtask

  task automatic test_wall_over;
    run_ticks(13);
    checks++; if (headY !== 10'd0) begin errors++; $display("FAIL wall_top_row got %0d exp 0", headY); end
    checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL wall_not_yet_over got %b exp 0", game_over); end
    run_ticks(1);
    checks++; if (game_over !== 1'b1) begin errors++; $display("FAIL wall_game_over got %b exp 1", game_over); end
    checks++; if (headY !== 10'd0) begin errors++; $display("FAIL wall_frozen_headY got %0d exp 0", headY); end
    run_ticks(1);
    checks++; if (headX !== 10'd152 || headY !== 10'd0) begin errors++; $display("FAIL over_frozen got %0d,%0d exp 152,0", headX, headY); end
    currentScreen = 2'b00;
    step(1);
    checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL over_to_idle got %b exp 0", game_over); end
  endtask

  task automatic test_pause;
    moveState = 2'b11;
    currentScreen = 2'b01;
    step(1);
    checks++; if (headX !== 10'd320 || headY !== 10'd240) begin errors++; $display("FAIL reinit_head got %0d,%0d exp 320,240", headX, headY); end
    checks++; if ({score4, score3, score2, score1} !== 16'h0000) begin errors++; $display("FAIL reinit_score got %h exp 0000", {score4, score3, score2, score1}); end
    checks++; if (foodX !== 10'd160) begin errors++; $display("FAIL reinit_foodX got %0d exp 160", foodX); end
    step(2);
    isPaused = 1'b1;
    step(20);
    checks++; if (headX !== 10'd320) begin errors++; $display("FAIL pause_hold got %0d exp 320", headX); end
    isPaused = 1'b0;
    step(1);
    checks++; if (headX !== 10'd320) begin errors++; $display("FAIL pause_count_held got %0d exp 320", headX); end
    step(1);
    checks++; if (headX !== 10'd328) begin errors++; $display("FAIL pause_resume_move got %0d exp 328", headX); end
  endtask

  task automatic eat_step(input int k);
    rand_x = (k == 10) ? 10'd700 : 10'((20 - k) * 8);
    rand_y = 10'd120;
    run_ticks(1);
  endtask

  task automatic test_score_food;
    moveState = 2'b00;
    run_ticks(15);
    moveState = 2'b10;
    run_ticks(20);
    checks++; if (headX !== 10'd168 || headY !== 10'd120) begin errors++; $display("FAIL chain_start got %0d,%0d exp 168,120", headX, headY); end
    for (int k = 1; k <= 3; k++) eat_step(k);
    rand_x = 10'd128; rand_y = 10'd120;
    pix_x = 10'd168; pix_y = 10'd120;
    step(1);
    checks++; if (body_on !== 1'b1) begin errors++; $display("FAIL body_active_tail got %b exp 1", body_on); end
    pix_x = 10'd176;
    step(1);
    checks++; if (body_on !== 1'b0) begin errors++; $display("FAIL body_beyond_len got %b exp 0", body_on); end
    step(2);
    for (int k = 5; k <= 10; k++) begin
      eat_step(k);
      if (k == 9) begin
        checks++; if ({score4, score3, score2, score1} !== 16'h0009) begin errors++; $display("FAIL score_0009 got %h exp 0009", {score4, score3, score2, score1}); end
      end
      if (k == 10) begin
        checks++; if ({score4, score3, score2, score1} !== 16'h0010) begin errors++; $display("FAIL score_carry_0010 got %h exp 0010", {score4, score3, score2, score1}); end
      end
    end
    step(3);
    checks++; if (foodX !== 10'd88) begin errors++; $display("FAIL food_held_invalid got %0d exp 88", foodX); end
    rand_x = 10'd40;
    step(1);
    checks++; if (foodX !== 10'd40 || foodY !== 10'd120) begin errors++; $display("FAIL food_retry_latch got %0d,%0d exp 40,120", foodX, foodY); end
    checks++; if (headX !== 10'd80) begin errors++; $display("FAIL chain_headX got %0d exp 80", headX); end
  endtask

  task automatic test_async_reset;
    #3;
    reset = 1'b1;
    #1;
    checks++; if (headX !== 10'd320 || headY !== 10'd240) begin errors++; $display("FAIL async_reset_head got %0d,%0d exp 320,240", headX, headY); end
    checks++; if (foodX !== 10'd160) begin errors++; $display("FAIL async_reset_food got %0d exp 160", foodX); end
    checks++; if ({score4, score3, score2, score1} !== 16'h0000) begin errors++; $display("FAIL async_reset_score got %h exp 0000", {score4, score3, score2, score1}); end
    #2;
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_bcd_wrap;
    bcd_clear = 1'b1;
    step(1);
    bcd_clear = 1'b0;
    bcd_inc = 1'b1;
    step(9);
    checks++; if (bcd_digits !== 16'h0009) begin errors++; $display("FAIL bcd_0009 got %h exp 0009", bcd_digits); end
    step(1);
    checks++; if (bcd_digits !== 16'h0010) begin errors++; $display("FAIL bcd_0010 got %h exp 0010", bcd_digits); end
    step(9989);
    checks++; if (bcd_digits !== 16'h9999) begin errors++; $display("FAIL bcd_9999 got %h exp 9999", bcd_digits); end
    step(1);
    checks++; if (bcd_digits !== 16'h0000) begin errors++; $display("FAIL bcd_wrap got %h exp 0000", bcd_digits); end
    bcd_inc = 1'b0;
  endtask

  initial begin
    test_reset();
    test_move();
    test_food();
    test_reverse();
    test_wall_over();
    test_pause();
    test_score_food();
    test_async_reset();
    test_bcd_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_snake_game_core
`default_nettype wire
